// File: rtl/riscv_defs_pkg.sv
// riscv_defs: RV32I format codes, opcodes, NOP and encoder word record
package riscv_defs;
  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_t;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_JAL    = 7'h6f;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_REG    = 7'h33;
  localparam logic [31:0] NOP = 32'h0000_0013;
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] addr;
    logic        err;
    logic        last;
  } enc_word_t;
endpackage

// File: rtl/instr_pack.sv
// instr_pack: combinational RV32I field/immediate scatter with range check (fmt, fields, imm -> instr, err)
module instr_pack
  import riscv_defs::*;
(
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic [31:0] instr,
  output logic        err
);
  always_comb begin
    instr = NOP;
    err   = 1'b1;
    case (fmt)
      FMT_R: begin
        instr = {funct7, rs2, rs1, funct3, rd, opcode};
        err   = 1'b0;
      end
      FMT_I: begin
        instr = {imm[11:0], rs1, funct3, rd, opcode};
        err   = imm != {{20{imm[11]}}, imm[11:0]};
      end
      FMT_S: begin
        instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        err   = imm != {{20{imm[11]}}, imm[11:0]};
      end
      FMT_B: begin
        instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        err   = (imm != {{19{imm[12]}}, imm[12:0]}) || imm[0];
      end
      FMT_U: begin
        instr = {imm[31:12], rd, opcode};
        err   = |imm[11:0];
      end
      FMT_J: begin
        instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        err   = (imm != {{11{imm[20]}}, imm[20:0]}) || imm[0];
      end
      default: begin
        instr = NOP;
        err   = 1'b1;
      end
    endcase
  end
endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: streams RV32I field tuples into encoded words via a 2-entry skid buffer with address tagging and stream-end flush
module instr_encoder
  import riscv_defs::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_fmt,
  input  logic [6:0]  in_opcode,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [31:0] in_imm,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic        out_err,
  output logic        out_last,
  output logic        done
);
  localparam logic [0:0] STREAM = 1'b0;
  localparam logic [0:0] FLUSH  = 1'b1;
  logic [0:0]  state;
  logic [1:0]  count;
  logic [31:0] addr;
  logic [31:0] pack_instr;
  logic        pack_err;
  logic        push;
  logic        pop;
  enc_word_t   e0;
  enc_word_t   e1;
  enc_word_t   new_word;
  instr_pack u_pack (
    .fmt(in_fmt),
    .opcode(in_opcode),
    .rd(in_rd),
    .rs1(in_rs1),
    .rs2(in_rs2),
    .funct3(in_funct3),
    .funct7(in_funct7),
    .imm(in_imm),
    .instr(pack_instr),
    .err(pack_err)
  );
  assign new_word  = '{instr: pack_instr, addr: addr, err: pack_err, last: in_last};
  // ready comes only from registered state so it never combinationally depends on out_ready
  assign in_ready  = (count != 2'd2) && (state == STREAM);
  assign out_valid = count != 2'd0;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_instr = e0.instr;
  assign out_addr  = e0.addr;
  assign out_err   = e0.err;
  assign out_last  = e0.last;
  assign done      = pop && e0.last;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= STREAM;
      count <= 2'd0;
      addr  <= BASE_ADDR;
      e0    <= '0;
      e1    <= '0;
    end else begin
      count <= count + {1'b0, push} - {1'b0, pop};
      // e0 is the head; on a pop it refills from e1 when full, else from the incoming word
      if (pop) e0 <= (count == 2'd2) ? e1 : new_word;
      else if (push && count == 2'd0) e0 <= new_word;
      if (push && count == 2'd1 && !pop) e1 <= new_word;
      if (push) addr <= in_last ? BASE_ADDR : addr + 32'd4;
      state <= (push && in_last) ? FLUSH : done ? STREAM : state;
    end
  end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed scoreboard bench for instr_encoder
module tb_instr_encoder;
  localparam logic [31:0] BASE = 32'h0000_0000;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_fmt = '0;
  logic [6:0]  in_opcode = '0;
  logic [4:0]  in_rd = '0;
  logic [4:0]  in_rs1 = '0;
  logic [4:0]  in_rs2 = '0;
  logic [2:0]  in_funct3 = '0;
  logic [6:0]  in_funct7 = '0;
  logic [31:0] in_imm = '0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic        out_err;
  logic        out_last;
  logic        done;
  typedef struct {
    logic [31:0] instr;
    logic [31:0] addr;
    logic        err;
    logic        last;
  } exp_t;
  exp_t        sb[$];
  exp_t        pend;
  logic [31:0] tb_addr = BASE;
  int          errors = 0;
  int          checks = 0;
  int          dones = 0;
  bit          acc;
  always #5 clk = ~clk;
  instr_encoder #(.BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7),
    .in_imm(in_imm), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_instr(out_instr), .out_addr(out_addr),
    .out_err(out_err), .out_last(out_last), .done(done)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick(output bit a);
    exp_t e;
    @(negedge clk);
    a = in_valid && in_ready;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) chk("sb_unexpected_word", out_instr, 32'hxxxx_xxxx);
      else begin
        e = sb.pop_front();
        chk("instr", out_instr, e.instr);
        chk("addr", out_addr, e.addr);
        chk("err", {31'd0, out_err}, {31'd0, e.err});
        chk("last", {31'd0, out_last}, {31'd0, e.last});
        chk("done_on_xfer", {31'd0, done}, {31'd0, e.last});
      end
    end else chk("done_idle", {31'd0, done}, 32'd0);
    if (done) dones++;
    if (a) begin
      e = pend;
      e.addr = tb_addr;
      sb.push_back(e);
      tb_addr = pend.last ? BASE : tb_addr + 32'd4;
    end
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [31:0] imm, input logic last,
                       input logic [31:0] ei, input logic ee);
    in_valid = 1'b1; in_fmt = f; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm; in_last = last;
    pend.instr = ei; pend.err = ee; pend.last = last; pend.addr = '0;
  endtask
  task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [31:0] imm, input logic last,
                      input logic [31:0] ei, input logic ee);
    bit a = 1'b0;
    drive(f, op, rd, rs1, rs2, f3, f7, imm, last, ei, ee);
    for (int i = 0; i < 20 && !a; i++) tick(a);
    chk("accept", {31'd0, a}, 32'd1);
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask
  task automatic addi(input logic [4:0] rd, input logic [31:0] imm, input logic last);
    send(3'd1, 7'h13, rd, 5'd0, 5'd0, 3'd0, 7'd0, imm, last, (imm << 20) | (32'(rd) << 7) | 32'h13, 1'b0);
  endtask
  task automatic drain();
    bit a;
    for (int i = 0; i < 20 && sb.size() != 0; i++) tick(a);
    chk("drain", sb.size(), 32'd0);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_addr", out_addr, 32'd0);
    chk("rst_out_err", {31'd0, out_err}, 32'd0);
    chk("rst_out_last", {31'd0, out_last}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    out_ready = 1'b1;
    send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b0, 32'h0050_0093, 1'b0);
    chk("latency_valid", {31'd0, out_valid}, 32'd1);
    drain();
    send(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8, 1'b0, 32'h0020_A423, 1'b0);
    send(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, -32'sd4, 1'b0, 32'hFE00_0EE3, 1'b0);
    send(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 1'b0, 32'h0010_00EF, 1'b0);
    send(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 1'b0, 32'h1234_52B7, 1'b0);
    send(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'hFFFF_FFFF, 1'b0, 32'h4020_81B3, 1'b0);
    send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 1'b0, 32'h8000_0093, 1'b1);
    send(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, 1'b0, 32'h0000_0163, 1'b1);
    send(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0123, 1'b0, 32'h0000_02B7, 1'b1);
    send(3'd7, 7'h33, 5'd3, 5'd1, 5'd2, 3'd1, 7'h7F, 32'd0, 1'b1, 32'h0000_0013, 1'b1);
    drain();
    chk("flush_released", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b0;
    addi(5'd1, 32'd10, 1'b0);
    addi(5'd2, 32'd20, 1'b0);
    chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    drive(3'd1, 7'h13, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd30, 1'b0, 32'h01E0_0193, 1'b0);
    tick(acc);
    chk("bp_hold_0", {31'd0, acc}, 32'd0);
    tick(acc);
    chk("bp_hold_1", {31'd0, acc}, 32'd0);
    out_ready = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) tick(acc);
    chk("bp_accept_third", {31'd0, acc}, 32'd1);
    in_valid = 1'b0;
    drain();
    dones = 0;
    for (int k = 0; k < 4; k++) begin
      drive(3'd1, 7'h13, 5'(k + 4), 5'd0, 5'd0, 3'd0, 7'd0, 32'(k + 100), k == 3,
            (32'(k + 100) << 20) | (32'(k + 4) << 7) | 32'h13, 1'b0);
      tick(acc);
      chk("stream_throughput", {31'd0, acc}, 32'd1);
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    chk("flush_in_ready", {31'd0, in_ready}, 32'd0);
    drain();
    chk("done_count", dones, 32'd1);
    chk("stream_back", {31'd0, in_ready}, 32'd1);
    addi(5'd9, 32'd1, 1'b0);
    drain();
    out_ready = 1'b0;
    addi(5'd10, 32'd2, 1'b0);
    addi(5'd11, 32'd3, 1'b0);
    chk("pre_rst_full", {31'd0, in_ready}, 32'd0);
    rst = 1'b1;
    tick(acc);
    rst = 1'b0;
    sb.delete();
    tb_addr = BASE;
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    addi(5'd12, 32'd4, 1'b0);
    drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_0000, SHALL be the byte address assigned to the first word of each program stream.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 in_valid  input  1  field tuple valid; in_ready  output  1  encoder can accept.
REQ-005 in_fmt  input  3  format code: R=0, I=1, S=2, B=3, U=4, J=5; codes 6 and 7 are illegal.
REQ-006 in_opcode[6:0], in_rd[4:0], in_rs1[4:0], in_rs2[4:0], in_funct3[2:0], in_funct7[6:0]  input  instruction fields.
REQ-007 in_imm  input  32  signed byte immediate; for U format, the full value with bits [11:0] zero.
REQ-008 in_last  input  1  marks the final tuple of a program stream.
REQ-009 out_valid  output  1  encoded word valid; out_ready  input  1  consumer accepts.
REQ-010 out_instr  output  32  encoded instruction word.
REQ-011 out_addr  output  32  byte address of out_instr.
REQ-012 out_err  output  1  immediate not representable, or illegal format, for this word.
REQ-013 out_last  output  1  the word carries in_last.
REQ-014 done  output  1  one-cycle pulse when the last word of a stream is accepted downstream.

Function
REQ-015 A transfer SHALL occur on any cycle with valid and ready both high; valid, once asserted, SHALL hold together with its payload until the transfer completes.
REQ-016 Field placement SHALL be the exact inverse of RV32I decode:
- opcode to [6:0], rd to [11:7], funct3 to [14:12], rs1 to [19:15], rs2 to [24:20], funct7 to [31:25].
- Fields unused by the selected format SHALL be ignored.
REQ-017 Immediate scatter by format:
- I: imm[11:0] to [31:20].
- S: imm[11:5] to [31:25], imm[4:0] to [11:7].
- B: imm[12|10:5] to [31|30:25], imm[4:1|11] to [11:8|7].
- U: imm[31:12] to [31:12].
- J: imm[20|10:1|11|19:12] to [31|30:21|20|19:12].
REQ-018 Range checks SHALL set out_err on these conditions:
- I/S: imm is not the sign-extension of imm[11:0].
- B: imm is not the sign-extension of imm[12:0], or imm[0]=1.
- J: imm is not the sign-extension of imm[20:0], or imm[0]=1.
- U: imm[11:0] is not zero.
- R: never.
REQ-019 On an out_err from a range check, the word SHALL still be encoded from the truncated immediate bits.
REQ-020 An illegal in_fmt SHALL produce out_instr=32'h0000_0013 (NOP) with out_err=1.
REQ-021 Latency SHALL be exactly one cycle from input transfer to out_valid when the output stage is empty.
REQ-022 The output stage SHALL be a 2-entry skid buffer.
- in_ready SHALL depend only on registered occupancy: ready while fewer than 2 entries are held.
- Full throughput of one word per cycle SHALL be sustained while out_ready stays high.
REQ-023 Simultaneous input and output transfers at occupancy 1 SHALL leave occupancy at 1 and preserve order.
REQ-024 Address counter:
- It SHALL hold BASE_ADDR at reset.
- Each input transfer SHALL tag the word with the current counter value, then increment the counter by 4.
- It SHALL wrap modulo 2^32.
REQ-025 An input transfer with in_last=1 SHALL reload the counter to BASE_ADDR, so the next tuple starts a new stream.
REQ-026 done SHALL pulse for one cycle on the output transfer of a word with out_last=1.
- Back-to-back last words SHALL produce back-to-back pulses.
REQ-027 Control FSM:
- States are STREAM and FLUSH.
- It enters FLUSH on an in_last input transfer.
- While in FLUSH, in_ready=0.
- It returns to STREAM on done.

Reset
REQ-028 rst SHALL synchronously reset the block with priority over all other activity, including mid-stream and mid-handshake.
REQ-029 Reset values:
- out_valid=0, out_instr=0, out_addr=0, out_err=0, out_last=0, done=0.
- in_ready=1 from the first cycle after reset.
- Counter=BASE_ADDR, FSM=STREAM, buffered words discarded.

Structure
REQ-030 Format codes, the NOP constant and the RV32I opcode constants SHALL reside in the shared riscv_defs definitions.
REQ-031 Field scatter and range check SHALL be one combinational sub-module, instr_pack.
- It takes the fields, imm and fmt.
- It returns the word and the err flag.
- The skid buffer, counter and FSM SHALL reside in instr_encoder.

Verification
REQ-032 I, rd=1, rs1=0, f3=0, op=0x13, imm=5 -> out_instr=0x00500093, out_addr=BASE_ADDR, out_err=0, one cycle later.
REQ-033 Field-scatter vectors:
- S, op=0x23, f3=2, rs1=1, rs2=2, imm=8 -> 0x0020A423.
- B, op=0x63, imm=-4 -> 0xFE000EE3.
- J, op=0x6F, rd=1, imm=2048 -> 0x001000EF.
- U, op=0x37, rd=5, imm=0x12345000 -> 0x123452B7.
REQ-034 Error vectors:
- I, imm=2048 -> 0x80000093, out_err=1.
- B, imm=3 -> out_err=1.
- fmt=7 -> 0x00000013, out_err=1.
REQ-035 Backpressure: 3 tuples with out_ready=0 -> in_ready drops after 2 accepted; out_ready=1 then yields all 3 words in order at addresses 0, 4, 8, with no loss or duplication.
REQ-036 Stream end: 4 tuples, the last with in_last=1 -> done pulses once on the 4th output transfer; the next tuple is tagged BASE_ADDR.
REQ-037 Reset: assert rst while holding 2 buffered words -> next cycle out_valid=0, in_ready=1; the next tuple is tagged BASE_ADDR.
